dispatch_rename: RTL and testbench

- Sits between the instruction queue and the reservation station / load-store buffer.
- Each cycle it takes at most one decoded instruction from the queue and allocates the ROB tag the ROB offers.
- Renames operands against an internal 32-entry register/tag file and resolves them through a CDB/commit/ROB bypass.
- Issues one registered packet to either the RS (ALU ops, branches, jumps) or the LSB (loads, stores).
- Owns architectural register values, updated at ROB commit.

---
 rtl/dispatch_rename_if.sv | 85 ++++++++
 rtl/dispatch_rename.sv | 188 ++++++++++++++++++
 tb/tb_dispatch_rename.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/dispatch_rename_if.sv
// Dispatch/rename bus bundle: instruction queue head, ROB allocation and lookup,
// RS/LSB issue packet, CDB broadcasts and ROB commit.
interface dispatch_rename_if #(
  parameter int XLEN   = 32,
  parameter int TAG_W  = 4,
  parameter int TYPE_W = 6
);
  // instruction queue head
  logic              iq_en_in;
  logic [TYPE_W-1:0] iq_inst_type_in;
  logic [4:0]        iq_rd_in;
  logic [4:0]        iq_rs1_in;
  logic [4:0]        iq_rs2_in;
  logic [XLEN-1:0]   iq_imm_in;
  logic [XLEN-1:0]   iq_pc_in;
  logic              iq_pop_out;

  // downstream space
  logic              rob_rdy_in;
  logic              rs_rdy_in;
  logic              lsb_rdy_in;

  // ROB allocation and operand lookup
  logic [TAG_W-1:0]  rob_free_tag_in;
  logic [TAG_W-1:0]  rob_qj_tag_out;
  logic [TAG_W-1:0]  rob_qk_tag_out;
  logic              rob_qj_ready_in;
  logic              rob_qk_ready_in;
  logic [XLEN-1:0]   rob_qj_value_in;
  logic [XLEN-1:0]   rob_qk_value_in;
  logic              rob_en_out;
  logic [4:0]        rob_rd_out;
  logic [TYPE_W-1:0] rob_inst_type_out;
  logic [XLEN-1:0]   rob_pc_out;

  // issue packet
  logic              rs_en_out;
  logic              lsb_en_out;
  logic [XLEN-1:0]   vj_out;
  logic [XLEN-1:0]   vk_out;
  logic [TAG_W-1:0]  qj_out;
  logic [TAG_W-1:0]  qk_out;
  logic [XLEN-1:0]   A_out;
  logic [TAG_W-1:0]  dest_out;
  logic [TYPE_W-1:0] inst_type_out;
  logic [XLEN-1:0]   pc_out;

  // result broadcasts and commit
  logic              cdb_alu_en_in;
  logic [TAG_W-1:0]  cdb_alu_dest_in;
  logic [XLEN-1:0]   cdb_alu_value_in;
  logic              cdb_lbuffer_en_in;
  logic [TAG_W-1:0]  cdb_lbuffer_dest_in;
  logic [XLEN-1:0]   cdb_lbuffer_value_in;
  logic              rob_commit_en_in;
  logic [4:0]        rob_commit_rd_in;
  logic [TAG_W-1:0]  rob_commit_tag_in;
  logic [XLEN-1:0]   rob_commit_value_in;

  modport master (
    input  iq_en_in, iq_inst_type_in, iq_rd_in, iq_rs1_in, iq_rs2_in, iq_imm_in, iq_pc_in,
    output iq_pop_out,
    input  rob_rdy_in, rs_rdy_in, lsb_rdy_in,
    input  rob_free_tag_in, rob_qj_ready_in, rob_qk_ready_in, rob_qj_value_in, rob_qk_value_in,
    output rob_qj_tag_out, rob_qk_tag_out, rob_en_out, rob_rd_out, rob_inst_type_out, rob_pc_out,
    output rs_en_out, lsb_en_out, vj_out, vk_out, qj_out, qk_out, A_out, dest_out,
    output inst_type_out, pc_out,
    input  cdb_alu_en_in, cdb_alu_dest_in, cdb_alu_value_in,
    input  cdb_lbuffer_en_in, cdb_lbuffer_dest_in, cdb_lbuffer_value_in,
    input  rob_commit_en_in, rob_commit_rd_in, rob_commit_tag_in, rob_commit_value_in
  );

  modport slave (
    output iq_en_in, iq_inst_type_in, iq_rd_in, iq_rs1_in, iq_rs2_in, iq_imm_in, iq_pc_in,
    input  iq_pop_out,
    output rob_rdy_in, rs_rdy_in, lsb_rdy_in,
    output rob_free_tag_in, rob_qj_ready_in, rob_qk_ready_in, rob_qj_value_in, rob_qk_value_in,
    input  rob_qj_tag_out, rob_qk_tag_out, rob_en_out, rob_rd_out, rob_inst_type_out, rob_pc_out,
    input  rs_en_out, lsb_en_out, vj_out, vk_out, qj_out, qk_out, A_out, dest_out,
    input  inst_type_out, pc_out,
    output cdb_alu_en_in, cdb_alu_dest_in, cdb_alu_value_in,
    output cdb_lbuffer_en_in, cdb_lbuffer_dest_in, cdb_lbuffer_value_in,
    output rob_commit_en_in, rob_commit_rd_in, rob_commit_tag_in, rob_commit_value_in
  );
endinterface

// File: rtl/dispatch_rename.sv
// Single-issue dispatch/rename stage: renames operands against a 32-entry value/tag file,
// resolves them through commit/CDB/ROB bypass and issues one registered packet to RS or LSB.

// Resolves one source operand; earlier bypass sources take priority.
module dr_operand #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 4
) (
  input  logic [4:0]       idx,
  input  logic [XLEN-1:0]  rf_val,
  input  logic [TAG_W-1:0] rf_tag,
  input  logic             commit_en,
  input  logic [TAG_W-1:0] commit_tag,
  input  logic [XLEN-1:0]  commit_value,
  input  logic             alu_en,
  input  logic [TAG_W-1:0] alu_dest,
  input  logic [XLEN-1:0]  alu_value,
  input  logic             lb_en,
  input  logic [TAG_W-1:0] lb_dest,
  input  logic [XLEN-1:0]  lb_value,
  input  logic             rob_ready,
  input  logic [XLEN-1:0]  rob_value,
  output logic [XLEN-1:0]  v,
  output logic [TAG_W-1:0] q
);
  always_comb begin
    v = '0;
    q = '0;
    if (idx == 5'd0) begin
      v = '0;
    end else if (rf_tag == '0) begin
      v = rf_val;
    end else if (commit_en && commit_tag == rf_tag) begin
      v = commit_value;
    end else if (alu_en && alu_dest == rf_tag) begin
      v = alu_value;
    end else if (lb_en && lb_dest == rf_tag) begin
      v = lb_value;
    end else if (rob_ready) begin
      v = rob_value;
    end else begin
      q = rf_tag;
    end
  end
endmodule

module dispatch_rename #(
  parameter int XLEN   = 32,
  parameter int TAG_W  = 4,
  parameter int TYPE_W = 6
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               rdy_in,
  input  logic               rob_flush_in,
  dispatch_rename_if.master  bus
);
  // Type codes: branches BEQ..BGEU = 5..10, loads LB..LHU = 11..15, stores SB..SW = 16..18.
  localparam logic [TYPE_W-1:0] T_BEQ  = TYPE_W'(5);
  localparam logic [TYPE_W-1:0] T_BGEU = TYPE_W'(10);
  localparam logic [TYPE_W-1:0] T_LB   = TYPE_W'(11);
  localparam logic [TYPE_W-1:0] T_SB   = TYPE_W'(16);
  localparam logic [TYPE_W-1:0] T_SW   = TYPE_W'(18);

  logic [31:0][XLEN-1:0]  val_q;
  logic [31:0][TAG_W-1:0] tag_q;

  logic              rob_en_q, rs_en_q, lsb_en_q;
  logic [4:0]        rob_rd_q;
  logic [XLEN-1:0]   vj_q, vk_q, a_q, pc_q;
  logic [TAG_W-1:0]  qj_q, qk_q, dest_q;
  logic [TYPE_W-1:0] type_q;

  logic [TYPE_W-1:0] ty;
  logic              is_mem, is_branch, is_store, writes_rd, go, rename;

  assign ty        = bus.iq_inst_type_in;
  assign is_mem    = (ty >= T_LB)  && (ty <= T_SW);
  assign is_branch = (ty >= T_BEQ) && (ty <= T_BGEU);
  assign is_store  = (ty >= T_SB)  && (ty <= T_SW);
  assign writes_rd = ~is_branch & ~is_store;

  assign go = rdy_in & ~rob_flush_in & ~rst_in & bus.iq_en_in & bus.rob_rdy_in &
              (is_mem ? bus.lsb_rdy_in : bus.rs_rdy_in);
  assign rename = go && writes_rd && (bus.iq_rd_in != 5'd0);

  assign bus.iq_pop_out     = go;
  assign bus.rob_qj_tag_out = tag_q[bus.iq_rs1_in];
  assign bus.rob_qk_tag_out = tag_q[bus.iq_rs2_in];

  // Operand 0 = rs1 (j), operand 1 = rs2 (k)
  logic [1:0][4:0]       src_idx;
  logic [1:0]            src_rob_rdy;
  logic [1:0][XLEN-1:0]  src_rob_val;
  logic [1:0][XLEN-1:0]  opnd_v;
  logic [1:0][TAG_W-1:0] opnd_q;

  assign src_idx     = {bus.iq_rs2_in, bus.iq_rs1_in};
  assign src_rob_rdy = {bus.rob_qk_ready_in, bus.rob_qj_ready_in};
  assign src_rob_val = {bus.rob_qk_value_in, bus.rob_qj_value_in};

  for (genvar i = 0; i < 2; i++) begin : g_opnd
    dr_operand #(.XLEN(XLEN), .TAG_W(TAG_W)) u_opnd (
      .idx          (src_idx[i]),
      .rf_val       (val_q[src_idx[i]]),
      .rf_tag       (tag_q[src_idx[i]]),
      .commit_en    (bus.rob_commit_en_in),
      .commit_tag   (bus.rob_commit_tag_in),
      .commit_value (bus.rob_commit_value_in),
      .alu_en       (bus.cdb_alu_en_in),
      .alu_dest     (bus.cdb_alu_dest_in),
      .alu_value    (bus.cdb_alu_value_in),
      .lb_en        (bus.cdb_lbuffer_en_in),
      .lb_dest      (bus.cdb_lbuffer_dest_in),
      .lb_value     (bus.cdb_lbuffer_value_in),
      .rob_ready    (src_rob_rdy[i]),
      .rob_value    (src_rob_val[i]),
      .v            (opnd_v[i]),
      .q            (opnd_q[i])
    );
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      val_q    <= '0;
      tag_q    <= '0;
      rob_en_q <= 1'b0;
      rs_en_q  <= 1'b0;
      lsb_en_q <= 1'b0;
      rob_rd_q <= '0;
      vj_q     <= '0;
      vk_q     <= '0;
      qj_q     <= '0;
      qk_q     <= '0;
      a_q      <= '0;
      dest_q   <= '0;
      type_q   <= '0;
      pc_q     <= '0;
    end else begin
      rob_en_q <= 1'b0;
      rs_en_q  <= 1'b0;
      lsb_en_q <= 1'b0;
      if (rdy_in) begin
        if (rob_flush_in) begin
          tag_q <= '0;
        end else begin
          if (bus.rob_commit_en_in && bus.rob_commit_rd_in != 5'd0) begin
            val_q[bus.rob_commit_rd_in] <= bus.rob_commit_value_in;
            if (tag_q[bus.rob_commit_rd_in] == bus.rob_commit_tag_in)
              tag_q[bus.rob_commit_rd_in] <= '0;
          end
          if (go) begin
            rob_en_q <= 1'b1;
            rs_en_q  <= ~is_mem;
            lsb_en_q <= is_mem;
            rob_rd_q <= writes_rd ? bus.iq_rd_in : 5'd0;
            vj_q     <= opnd_v[0];
            qj_q     <= opnd_q[0];
            vk_q     <= opnd_v[1];
            qk_q     <= opnd_q[1];
            a_q      <= bus.iq_imm_in;
            dest_q   <= bus.rob_free_tag_in;
            type_q   <= ty;
            pc_q     <= bus.iq_pc_in;
          end
          // Placed after the commit clear so a same-cycle rename of rd wins.
          if (rename)
            tag_q[bus.iq_rd_in] <= bus.rob_free_tag_in;
        end
      end
    end
  end

  assign bus.rob_en_out        = rob_en_q;
  assign bus.rob_rd_out        = rob_rd_q;
  assign bus.rob_inst_type_out = type_q;
  assign bus.rob_pc_out        = pc_q;
  assign bus.rs_en_out         = rs_en_q;
  assign bus.lsb_en_out        = lsb_en_q;
  assign bus.vj_out            = vj_q;
  assign bus.vk_out            = vk_q;
  assign bus.qj_out            = qj_q;
  assign bus.qk_out            = qk_q;
  assign bus.A_out             = a_q;
  assign bus.dest_out          = dest_q;
  assign bus.inst_type_out     = type_q;
  assign bus.pc_out            = pc_q;
endmodule

// File: tb/tb_dispatch_rename.sv
// Scoreboard bench for dispatch_rename: stimulus pushes expected packets, a negedge monitor pops them.
module tb_dispatch_rename;
  localparam logic [5:0] T_BEQ = 6'd5, T_LW = 6'd13, T_SW = 6'd18, T_ADDI = 6'd19, T_ADD = 6'd28;

  logic clk = 1'b0, rst = 1'b1, rdy = 1'b1, flush = 1'b0;
  always #5 clk = ~clk;

  dispatch_rename_if #(.XLEN(32), .TAG_W(4), .TYPE_W(6)) bus ();
  dispatch_rename #(.XLEN(32), .TAG_W(4), .TYPE_W(6)) dut (
    .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .rob_flush_in(flush), .bus(bus)
  );

  typedef struct packed {
    logic rob_en; logic rs; logic lsb;
    logic [31:0] vj; logic [3:0] qj; logic [31:0] vk; logic [3:0] qk;
    logic [31:0] a; logic [3:0] dest; logic [5:0] typ; logic [31:0] pc; logic [4:0] rob_rd;
  } pkt_t;

  pkt_t sb[$];
  int n_cmp = 0, n_err = 0;
  logic [31:0] pc = 32'h100;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: any enable pulse must match the oldest expected packet.
  always @(negedge clk) begin
    pkt_t act, exp;
    if (!rst && (bus.rob_en_out || bus.rs_en_out || bus.lsb_en_out)) begin
      act = '{bus.rob_en_out, bus.rs_en_out, bus.lsb_en_out, bus.vj_out, bus.qj_out, bus.vk_out,
              bus.qk_out, bus.A_out, bus.dest_out, bus.inst_type_out, bus.pc_out, bus.rob_rd_out};
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_issue: got %h expected none", act);
      end else begin
        exp = sb.pop_front();
        if (act !== exp || bus.rob_pc_out !== exp.pc || bus.rob_inst_type_out !== exp.typ) begin
          n_err++;
          $display("FAIL packet: got %h expected %h", act, exp);
        end
      end
    end
  end

  task automatic clr_side();
    bus.cdb_alu_en_in = 0; bus.cdb_lbuffer_en_in = 0; bus.rob_commit_en_in = 0;
    bus.rob_qj_ready_in = 0; bus.rob_qk_ready_in = 0;
  endtask

  task automatic step();
    @(posedge clk); #1;
    bus.iq_en_in = 0;
    clr_side();
  endtask

  task automatic put(input logic [5:0] typ, input logic [4:0] rd, rs1, rs2,
                     input logic [31:0] imm, input logic [3:0] tg);
    bus.iq_en_in = 1; bus.iq_inst_type_in = typ; bus.iq_rd_in = rd;
    bus.iq_rs1_in = rs1; bus.iq_rs2_in = rs2; bus.iq_imm_in = imm; bus.iq_pc_in = pc;
    bus.rob_free_tag_in = tg;
  endtask

  // Present an instruction expected to dispatch now, queue its packet, advance one cycle.
  task automatic send(input logic [5:0] typ, input logic [4:0] rd, rs1, rs2,
                      input logic [31:0] imm, input logic [3:0] tg, input logic lsb,
                      input logic [31:0] vj, input logic [3:0] qj,
                      input logic [31:0] vk, input logic [3:0] qk, input logic [4:0] rob_rd);
    put(typ, rd, rs1, rs2, imm, tg);
    #1 chk("iq_pop", {31'd0, bus.iq_pop_out}, 32'd1);
    sb.push_back('{1'b1, ~lsb, lsb, vj, qj, vk, qk, imm, tg, typ, pc, rob_rd});
    pc = pc + 32'd4;
    step();
  endtask

  task automatic tag_of(input string name, input logic [4:0] r, input logic [3:0] exp);
    bus.iq_rs1_in = r;
    #1 chk(name, {28'd0, bus.rob_qj_tag_out}, {28'd0, exp});
  endtask

  initial begin
    bus.iq_en_in = 0; bus.iq_inst_type_in = '0; bus.iq_rd_in = '0; bus.iq_rs1_in = '0;
    bus.iq_rs2_in = '0; bus.iq_imm_in = '0; bus.iq_pc_in = '0; bus.rob_free_tag_in = 4'd1;
    bus.rob_rdy_in = 1; bus.rs_rdy_in = 1; bus.lsb_rdy_in = 1;
    bus.rob_qj_value_in = '0; bus.rob_qk_value_in = '0;
    bus.cdb_alu_dest_in = '0; bus.cdb_alu_value_in = '0;
    bus.cdb_lbuffer_dest_in = '0; bus.cdb_lbuffer_value_in = '0;
    bus.rob_commit_rd_in = '0; bus.rob_commit_tag_in = '0; bus.rob_commit_value_in = '0;
    clr_side();
    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk("rst_rob_en", {31'd0, bus.rob_en_out}, 32'd0);
    chk("rst_rs_en", {31'd0, bus.rs_en_out}, 32'd0);
    chk("rst_dest", {28'd0, bus.dest_out}, 32'd0);
    chk("rst_vj", bus.vj_out, 32'd0);
    tag_of("rst_tag_x1", 5'd1, 4'd0);

    // ADDI x1,x0,5 -> tag[1]=3
    send(T_ADDI, 5'd1, 5'd0, 5'd0, 32'd5, 4'd3, 0, 32'd0, 4'd0, 32'd0, 4'd0, 5'd1);
    tag_of("tag_x1_3", 5'd1, 4'd3);
    // ADD x2,x1,x1 while x1 pending
    send(T_ADD, 5'd2, 5'd1, 5'd1, 32'd0, 4'd5, 0, 32'd0, 4'd3, 32'd0, 4'd3, 5'd2);
    // same with ALU broadcast of tag 3
    bus.cdb_alu_en_in = 1; bus.cdb_alu_dest_in = 4'd3; bus.cdb_alu_value_in = 32'd5;
    send(T_ADD, 5'd2, 5'd1, 5'd1, 32'd0, 4'd6, 0, 32'd5, 4'd0, 32'd5, 4'd0, 5'd2);
    // commit x1 (tag 3) while ADDI x1 renames to tag 4: rename wins
    bus.rob_commit_en_in = 1; bus.rob_commit_rd_in = 5'd1; bus.rob_commit_tag_in = 4'd3;
    bus.rob_commit_value_in = 32'd5;
    send(T_ADDI, 5'd1, 5'd0, 5'd0, 32'd7, 4'd4, 0, 32'd0, 4'd0, 32'd0, 4'd0, 5'd1);
    tag_of("tag_x1_4", 5'd1, 4'd4);
    send(T_ADD, 5'd7, 5'd1, 5'd0, 32'd0, 4'd7, 0, 32'd0, 4'd4, 32'd0, 4'd0, 5'd7);
    // ROB-ready bypass on rs1, rs2 (x2 tag 6) still pending
    bus.rob_qj_ready_in = 1; bus.rob_qj_value_in = 32'h55;
    send(T_ADD, 5'd8, 5'd1, 5'd2, 32'd0, 4'd8, 0, 32'h55, 4'd0, 32'd0, 4'd6, 5'd8);
    // load-buffer bypass on x2
    bus.cdb_lbuffer_en_in = 1; bus.cdb_lbuffer_dest_in = 4'd6; bus.cdb_lbuffer_value_in = 32'h66;
    send(T_ADD, 5'd9, 5'd2, 5'd1, 32'd0, 4'd9, 0, 32'h66, 4'd0, 32'd0, 4'd4, 5'd9);
    // commit beats ALU when both match; commit of x1 tag 4 clears tag[1]
    bus.rob_commit_en_in = 1; bus.rob_commit_rd_in = 5'd1; bus.rob_commit_tag_in = 4'd4;
    bus.rob_commit_value_in = 32'h11;
    bus.cdb_alu_en_in = 1; bus.cdb_alu_dest_in = 4'd4; bus.cdb_alu_value_in = 32'h22;
    send(T_ADD, 5'd10, 5'd1, 5'd0, 32'd0, 4'd10, 0, 32'h11, 4'd0, 32'd0, 4'd0, 5'd10);
    tag_of("tag_x1_clr", 5'd1, 4'd0);

    // LW x5,8(x1) held while LSB full
    bus.lsb_rdy_in = 0;
    put(T_LW, 5'd5, 5'd1, 5'd0, 32'd8, 4'd11);
    for (int i = 0; i < 2; i++) begin
      #1 chk("pop_lsb_full", {31'd0, bus.iq_pop_out}, 32'd0);
      @(posedge clk); #1;
    end
    bus.lsb_rdy_in = 1; bus.rob_rdy_in = 0;
    #1 chk("pop_rob_full", {31'd0, bus.iq_pop_out}, 32'd0);
    @(posedge clk); #1;
    bus.rob_rdy_in = 1;
    send(T_LW, 5'd5, 5'd1, 5'd0, 32'd8, 4'd11, 1, 32'h11, 4'd0, 32'd0, 4'd0, 5'd5);

    // commit x2 (tag 6), then flush with tags outstanding and a stray commit
    bus.rob_commit_en_in = 1; bus.rob_commit_rd_in = 5'd2; bus.rob_commit_tag_in = 4'd6;
    bus.rob_commit_value_in = 32'h200;
    step();
    tag_of("tag_x5_pre", 5'd5, 4'd11);
    flush = 1;
    bus.rob_commit_en_in = 1; bus.rob_commit_rd_in = 5'd1; bus.rob_commit_tag_in = 4'd0;
    bus.rob_commit_value_in = 32'h999;
    put(T_ADD, 5'd3, 5'd1, 5'd2, 32'd0, 4'd12);
    #1 chk("pop_flush", {31'd0, bus.iq_pop_out}, 32'd0);
    @(posedge clk); #1;
    flush = 0; clr_side();
    tag_of("tag_x5_flush", 5'd5, 4'd0);
    tag_of("tag_x7_flush", 5'd7, 4'd0);
    send(T_ADD, 5'd3, 5'd1, 5'd2, 32'd0, 4'd12, 0, 32'h11, 4'd0, 32'h200, 4'd0, 5'd3);

    // stores and branches do not rename
    send(T_SW, 5'd4, 5'd1, 5'd2, 32'd0, 4'd13, 1, 32'h11, 4'd0, 32'h200, 4'd0, 5'd0);
    tag_of("tag_x4_sw", 5'd4, 4'd0);
    send(T_BEQ, 5'd6, 5'd3, 5'd1, 32'h40, 4'd14, 0, 32'd0, 4'd12, 32'h11, 4'd0, 5'd0);
    tag_of("tag_x6_beq", 5'd6, 4'd0);

    // rdy low for 3 cycles: head held, commit ignored
    rdy = 0;
    bus.rob_commit_en_in = 1; bus.rob_commit_rd_in = 5'd3; bus.rob_commit_tag_in = 4'd12;
    bus.rob_commit_value_in = 32'h333;
    put(T_ADD, 5'd4, 5'd3, 5'd0, 32'd0, 4'd15);
    for (int i = 0; i < 3; i++) begin
      #1 chk("pop_rdy_low", {31'd0, bus.iq_pop_out}, 32'd0);
      @(posedge clk); #1;
    end
    rdy = 1; clr_side();
    tag_of("tag_x3_hold", 5'd3, 4'd12);
    send(T_ADD, 5'd4, 5'd3, 5'd0, 32'd0, 4'd15, 0, 32'd0, 4'd12, 32'd0, 4'd0, 5'd4);
    tag_of("tag_x4_add", 5'd4, 4'd15);

    repeat (3) @(posedge clk);
    #1 chk("sb_drained", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
